fb_sram_arbiter: RTL and testbench
==================================

Name: fb_sram_arbiter

Overview:
- Single-port arbiter and sequencer for the framebuffer SRAM (32K x 8), shared between video scanout reads and CPU write posts.
- Drives the SRAM strobes, the address bus, and the two halves of the bus-switch pair: OE1 selects the video path, OE2 selects the CPU path.
- Video reads have strict priority. CPU writes are buffered in a small posting FIFO and retired in free slots.

Parameters:
- ADDR_W, 15, SRAM address width.
- DATA_W, 8, SRAM data width.
- FIFO_DEPTH, 4, write-post FIFO entries; must be a power of 2 and >= 2.
- WE_CYCLES, 2, number of clk cycles sram_we_n is held low per write; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- vid_req  in  1  scanout requests one read; sampled only when the arbiter is deciding.
- vid_addr  in  ADDR_W  scanout read address.
- vid_ack  out  1  one-cycle pulse: request accepted, address latched.
- vid_data  out  DATA_W  read data.
- vid_valid  out  1  one-cycle pulse: vid_data is valid.
- cpu_wr_valid  in  1  CPU posts a write.
- cpu_wr_addr  in  ADDR_W  write address.
- cpu_wr_data  in  DATA_W  write data.
- cpu_wr_ready  out  1  FIFO can accept an entry.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- sram_a  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  data driven toward the SRAM IO pins.
- sram_dout_en  out  1  enables the sram_dout tristate driver.
- sram_din  in  DATA_W  SRAM IO pins as read back.
- sram_cs_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low.
- bus_oe1_n, bus_oe2_n  out  1 each  bus-switch enables, active low.

Behaviour:
Registered outputs
- All SRAM, bus and vid_* outputs are registered; no combinational path from inputs to strobes.
- Reset values: all strobes and bus_oe*_n = 1; sram_dout_en = 0; vid_ack = 0; vid_valid = 0; vid_data = 0; sram_a = 0; sram_dout = 0; fifo_count = 0; cpu_wr_ready = 1.

Decision point
- Taken in IDLE, and also on the last cycle of RD_CAP and of WR_HOLD, so back-to-back operations need no idle gap.
- Priority: vid_req -> RD; else FIFO non-empty -> WR_SETUP; else IDLE.

States
- IDLE: strobes inactive, both bus switches off, sram_dout_en = 0.
- RD, 1 cycle: sram_a = latched vid_addr; cs_n = 0; oe_n = 0; bus_oe1_n = 0; vid_ack = 1.
- RD_CAP, 1 cycle: same drive as RD. sram_din is captured into vid_data at the end of the cycle, and vid_valid pulses the following cycle.
- Read latency: vid_req sampled at edge T gives vid_ack in cycle T+1 and vid_valid in cycle T+3. Maximum throughput is one read per 2 cycles.
- WR_SETUP, 1 cycle: sram_a and sram_dout = FIFO head; cs_n = 0; we_n = 1; oe_n = 1; sram_dout_en = 1; bus_oe2_n = 0.
- WR_PULSE, WE_CYCLES cycles: as WR_SETUP, with we_n = 0.
- WR_HOLD, 1 cycle: we_n = 1; address and data held; FIFO pops at the end of the cycle.
- A write occupies WE_CYCLES+2 cycles.

Invariants
- bus_oe1_n and bus_oe2_n are never both 0.
- sram_dout_en = 1 implies sram_oe_n = 1.
- sram_we_n = 0 only with sram_cs_n = 0; address and data are stable for the whole of WR_SETUP through WR_HOLD.

FIFO
- Push when cpu_wr_valid && cpu_wr_ready.
- cpu_wr_ready = (fifo_count < FIFO_DEPTH), registered. A pop in the same cycle does not raise ready early.
- Simultaneous push and pop: count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH.
- Push while full is ignored; no entry is corrupted.
- Entries are written to the SRAM in FIFO order.

Reset mid-operation
- The next edge forces IDLE, flushes the FIFO, and clears vid_valid and vid_ack.
- An aborted WR_PULSE leaves that SRAM byte undefined. This is acceptable.

Optional Feature:
FB_WR_STARVE_GUARD_EN
- Enabled: a 3-bit counter counts consecutive RD grants while the FIFO is non-empty. At 4, the next decision grants a write regardless of vid_req. The counter clears on any write grant or when the FIFO is empty.
- Disabled: strict video priority; writes can starve indefinitely.

Test Plan:
- Reset, then idle 5 cycles -> all strobes 1, bus_oe1_n = bus_oe2_n = 1, cpu_wr_ready = 1, fifo_count = 0.
- Preload SRAM[0x1234] = 0xA5; pulse vid_req with vid_addr = 0x1234 at edge T -> vid_ack in cycle T+1, vid_valid with vid_data = 0xA5 in cycle T+3, oe_n low exactly 2 cycles.
- Post 0x0010 <= 0x3C with no video traffic, WE_CYCLES = 2 -> WR_SETUP, 2 cycles of we_n = 0, WR_HOLD; SRAM[0x0010] = 0x3C; fifo_count returns to 0.
- Post 5 writes back-to-back with vid_req held high -> cpu_wr_ready drops after 4, the 5th write is not accepted, and fifo_count = 4.
  - Macro disabled: no write issues while vid_req is high.
  - Macro enabled: a write issues after 4 reads.
- Hold vid_req high and post a write simultaneously -> the read wins. After vid_req drops, the write completes and the invariants hold on every cycle.
- Assert rst during a WR_PULSE cycle with fifo_count = 3 -> next cycle all strobes 1, fifo_count = 0, vid_valid = 0.

Source files
------------

// File: rtl/fb_sram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fb_sram_arbiter                                                             |
// | Framebuffer SRAM sequencer: priority video reads, posted CPU writes.        |
// | Optional: define FB_WR_STARVE_GUARD_EN to force a write after 4 reads.      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module fb_sram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vid_req,
    input  logic [ADDR_W-1:0]             vid_addr,
    output logic                          vid_ack,
    output logic [DATA_W-1:0]             vid_data,
    output logic                          vid_valid,
    input  logic                          cpu_wr_valid,
    input  logic [ADDR_W-1:0]             cpu_wr_addr,
    input  logic [DATA_W-1:0]             cpu_wr_data,
    output logic                          cpu_wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [ADDR_W-1:0]             sram_a,
    output logic [DATA_W-1:0]             sram_dout,
    output logic                          sram_dout_en,
    input  logic [DATA_W-1:0]             sram_din,
    output logic                          sram_cs_n,
    output logic                          sram_oe_n,
    output logic                          sram_we_n,
    output logic                          bus_oe1_n,
    output logic                          bus_oe2_n
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WE_W  = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_RD_CAP   = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, head_idx;
    logic [CNT_W-1:0]  count_next;
    logic [WE_W-1:0]   we_cnt;
    logic              push, pop, decide, pending, force_wr;
    logic              rd_d, wr_d;

    // Occupancy seen by the decision excludes the entry popping this cycle,
    // so a WR_HOLD -> WR_SETUP chain only happens when another entry exists.
    always_comb begin
        push       = cpu_wr_valid && cpu_wr_ready;
        pop        = (state == S_WR_HOLD);
        decide     = (state == S_IDLE) || (state == S_RD_CAP) || pop;
        pending    = pop ? (fifo_count > CNT_W'(1)) : (fifo_count != '0);
        head_idx   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

`ifdef FB_WR_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign force_wr = (starve_cnt >= 3'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_count == '0) begin
            starve_cnt <= '0;
        end else if (decide && next_state == S_WR_SETUP) begin
            starve_cnt <= '0;
        end else if (decide && next_state == S_RD && pending && starve_cnt != 3'd7) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (decide) begin
            if (pending && force_wr) begin
                next_state = S_WR_SETUP;
            end else if (vid_req) begin
                next_state = S_RD;
            end else if (pending) begin
                next_state = S_WR_SETUP;
            end else begin
                next_state = S_IDLE;
            end
        end else begin
            case (state)
                S_RD:       next_state = S_RD_CAP;
                S_WR_SETUP: next_state = S_WR_PULSE;
                S_WR_PULSE: if (we_cnt == WE_W'(WE_CYCLES - 1)) next_state = S_WR_HOLD;
                default:    next_state = S_IDLE;
            endcase
        end
        rd_d = (next_state == S_RD) || (next_state == S_RD_CAP);
        wr_d = (next_state == S_WR_SETUP) || (next_state == S_WR_PULSE) ||
               (next_state == S_WR_HOLD);
    end

    // Strobes are registered from the next state so they switch on the same
    // edge as the state register, with no input-to-pin combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_cs_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_dout_en <= 1'b0;
            bus_oe1_n    <= 1'b1;
            bus_oe2_n    <= 1'b1;
            vid_ack      <= 1'b0;
            vid_valid    <= 1'b0;
            vid_data     <= '0;
            sram_a       <= '0;
            sram_dout    <= '0;
            we_cnt       <= '0;
        end else begin
            sram_cs_n    <= !(rd_d || wr_d);
            sram_oe_n    <= !rd_d;
            sram_we_n    <= (next_state != S_WR_PULSE);
            sram_dout_en <= wr_d;
            bus_oe1_n    <= !rd_d;
            bus_oe2_n    <= !wr_d;
            vid_ack      <= (next_state == S_RD);
            vid_valid    <= (state == S_RD_CAP);
            if (state == S_RD_CAP) begin
                vid_data <= sram_din;
            end
            if (next_state == S_RD) begin
                sram_a <= vid_addr;
            end else if (next_state == S_WR_SETUP) begin
                sram_a    <= fifo_addr[head_idx];
                sram_dout <= fifo_data[head_idx];
            end
            we_cnt <= (state == S_WR_PULSE) ? we_cnt + WE_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr;
            fifo_data[wr_ptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            cpu_wr_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count   <= count_next;
            cpu_wr_ready <= (count_next < CNT_W'(FIFO_DEPTH));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_sram_arbiter.sv
`default_nettype none
// Testbench for fb_sram_arbiter: behavioural SRAM, read/write scoreboards and
// per-scenario directed checks.
module tb_fb_sram_arbiter;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int WE_CYCLES  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              cpu_wr_valid;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_ready;
    logic [2:0]        fifo_count;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_dout;
    logic              sram_dout_en;
    logic [DATA_W-1:0] sram_din;
    logic              sram_cs_n, sram_oe_n, sram_we_n;
    logic              bus_oe1_n, bus_oe2_n;

    fb_sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .WE_CYCLES(WE_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(cpu_wr_ready),
        .fifo_count(fifo_count),
        .sram_a(sram_a), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_din(sram_din), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .bus_oe1_n(bus_oe1_n), .bus_oe2_n(bus_oe2_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM; read data settles by mid-cycle, well before capture.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_a  = '0;
    logic [DATA_W-1:0] pl_d  = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        if (!sram_cs_n && !sram_we_n && sram_dout_en) mem[sram_a] <= sram_dout;
    end

    always @(negedge clk) begin
        sram_din = (!sram_cs_n && !sram_oe_n) ? mem[sram_a] : 8'hEE;
    end

    int                errors = 0;
    int                checks = 0;
    logic              mon_en = 1'b0;
    logic              prev_we_n = 1'b1;
    logic [ADDR_W-1:0] cur_a = '0;
    logic [DATA_W-1:0] cur_d = '0;
    int                n_ack = 0;
    int                n_wr_start = 0;
    logic [DATA_W-1:0] exp_rd [$];
    wr_t               exp_wr [$];

    // Advance to the next falling edge and run the scoreboards/invariants.
    task automatic tick();
        logic [DATA_W-1:0] e;
        wr_t               w;
        @(negedge clk);
        if (mon_en) begin
            checks++;
            if ((!bus_oe1_n && !bus_oe2_n) || (sram_dout_en && !sram_oe_n) ||
                (!sram_we_n && sram_cs_n)) begin
                errors++;
                $display("FAIL invariant: oe1_n=%b oe2_n=%b dout_en=%b oe_n=%b we_n=%b cs_n=%b, required no conflict",
                         bus_oe1_n, bus_oe2_n, sram_dout_en, sram_oe_n, sram_we_n, sram_cs_n);
            end
            if (vid_ack) begin
                n_ack++;
                exp_rd.push_back(mem[vid_addr]);
            end
            if (vid_valid) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_scoreboard: vid_valid with data %h, required no pending read", vid_data);
                end else begin
                    e = exp_rd.pop_front();
                    if (vid_data !== e) begin
                        errors++;
                        $display("FAIL rd_scoreboard: vid_data=%h required %h", vid_data, e);
                    end
                end
            end
            if (!sram_we_n && prev_we_n) begin
                n_wr_start++;
                checks++;
                cur_a = sram_a;
                cur_d = sram_dout;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_scoreboard: write %h<=%h, required none pending", sram_a, sram_dout);
                end else begin
                    w = exp_wr.pop_front();
                    if (sram_a !== w.a || sram_dout !== w.d) begin
                        errors++;
                        $display("FAIL wr_scoreboard: write %h<=%h required %h<=%h", sram_a, sram_dout, w.a, w.d);
                    end
                end
            end
            if (sram_we_n && !prev_we_n && !sram_cs_n) begin
                checks++;
                if (sram_a !== cur_a || sram_dout !== cur_d) begin
                    errors++;
                    $display("FAIL wr_stable: hold %h<=%h required %h<=%h", sram_a, sram_dout, cur_a, cur_d);
                end
            end
        end
        prev_we_n = sram_we_n;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic post(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_wr_valid = 1'b1; cpu_wr_addr = a; cpu_wr_data = d;
        if (cpu_wr_ready && !rst) exp_wr.push_back('{a: a, d: d});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(fifo_count == 0 && sram_cs_n) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_drain: fifo_count=%0d cs_n=%b after 100 cycles, required 0 and 1", name, fifo_count, sram_cs_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (5) tick();
        checks++;
        if ({sram_cs_n, sram_oe_n, sram_we_n, bus_oe1_n, bus_oe2_n} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes: cs,oe,we,oe1,oe2=%b required 11111",
                     {sram_cs_n, sram_oe_n, sram_we_n, bus_oe1_n, bus_oe2_n});
        end
        checks++;
        if (cpu_wr_ready !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo: ready=%b count=%0d required 1 and 0", cpu_wr_ready, fifo_count);
        end
        checks++;
        if ({sram_dout_en, vid_ack, vid_valid} !== 3'b000 || vid_data !== 8'h00 ||
            sram_a !== '0 || sram_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: dout_en,ack,valid=%b vid_data=%h a=%h dout=%h required all 0",
                     {sram_dout_en, vid_ack, vid_valid}, vid_data, sram_a, sram_dout);
        end
    endtask

    task automatic test_read();
        logic [4:0]        ack_pat, val_pat;
        int                oe_cnt;
        logic [DATA_W-1:0] seen;
        preload(15'h1234, 8'hA5);
        ack_pat = '0; val_pat = '0; oe_cnt = 0; seen = '0;
        vid_req = 1'b1; vid_addr = 15'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) vid_req = 1'b0;
            ack_pat[i] = vid_ack;
            val_pat[i] = vid_valid;
            if (!sram_oe_n) oe_cnt++;
            if (vid_valid) seen = vid_data;
        end
        checks++;
        if (ack_pat !== 5'b00001) begin
            errors++;
            $display("FAIL read_ack_latency: pattern=%b required 00001", ack_pat);
        end
        checks++;
        if (val_pat !== 5'b00100) begin
            errors++;
            $display("FAIL read_valid_latency: pattern=%b required 00100", val_pat);
        end
        checks++;
        if (seen !== 8'hA5) begin
            errors++;
            $display("FAIL read_data: vid_data=%h required a5", seen);
        end
        checks++;
        if (oe_cnt != 2) begin
            errors++;
            $display("FAIL read_oe_width: oe_n low %0d cycles, required 2", oe_cnt);
        end
    endtask

    task automatic test_write();
        logic [6:0] we_pat, den_pat;
        logic [4:0] setup_vec;
        logic [2:0] cnt1;
        we_pat = '0; den_pat = '0; setup_vec = '0; cnt1 = '0;
        post(15'h0010, 8'h3C);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) begin
                cpu_wr_valid = 1'b0;
                cnt1 = fifo_count;
            end
            if (i == 1) setup_vec = {sram_cs_n, sram_we_n, sram_oe_n, bus_oe2_n, bus_oe1_n};
            we_pat[i]  = !sram_we_n;
            den_pat[i] = sram_dout_en;
        end
        checks++;
        if (cnt1 !== 3'd1) begin
            errors++;
            $display("FAIL write_count_up: fifo_count=%0d required 1", cnt1);
        end
        checks++;
        if (setup_vec !== 5'b01101) begin
            errors++;
            $display("FAIL write_setup: cs,we,oe,oe2,oe1=%b required 01101", setup_vec);
        end
        checks++;
        if (we_pat !== 7'b0001100) begin
            errors++;
            $display("FAIL write_we_pulse: we low pattern=%b required 0001100", we_pat);
        end
        checks++;
        if (den_pat !== 7'b0011110) begin
            errors++;
            $display("FAIL write_dout_en: pattern=%b required 0011110", den_pat);
        end
        checks++;
        if (mem[15'h0010] !== 8'h3C || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL write_result: mem=%h count=%0d required 3c and 0", mem[15'h0010], fifo_count);
        end
    endtask

    task automatic test_full_starve();
        int ack0, wr0, first_wr_acks;
        preload(15'h0200, 8'h5A);
        ack0 = n_ack; wr0 = n_wr_start; first_wr_acks = -1;
        post(15'h0100, 8'h11);
        tick();
        vid_req = 1'b1; vid_addr = 15'h0200;
        post(15'h0101, 8'h22); tick();
        post(15'h0102, 8'h33); tick();
        post(15'h0103, 8'h44); tick();
        post(15'h0104, 8'h55); tick();
        cpu_wr_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || cpu_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: count=%0d ready=%b required 4 and 0", fifo_count, cpu_wr_ready);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (first_wr_acks < 0 && n_wr_start != wr0) first_wr_acks = n_ack - ack0;
        end
`ifdef FB_WR_STARVE_GUARD_EN
        checks++;
        if (first_wr_acks != 4) begin
            errors++;
            $display("FAIL starve_guard: reads before first write=%0d required 4", first_wr_acks);
        end
`else
        checks++;
        if (n_wr_start != wr0 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL strict_priority: writes=%0d count=%0d required 0 and 4", n_wr_start - wr0, fifo_count);
        end
`endif
        vid_req = 1'b0;
        drain("full");
        repeat (2) tick();
        checks++;
        if (n_wr_start - wr0 != 4 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL full_writes: issued=%0d pending=%0d required 4 and 0", n_wr_start - wr0, exp_wr.size());
        end
        checks++;
        if ({mem[15'h0100], mem[15'h0101], mem[15'h0102], mem[15'h0103]} !== 32'h11223344) begin
            errors++;
            $display("FAIL full_mem: %h%h%h%h required 11223344",
                     mem[15'h0100], mem[15'h0101], mem[15'h0102], mem[15'h0103]);
        end
    endtask

    task automatic test_read_wins();
        int we_low;
        we_low = 0;
        vid_req = 1'b1; vid_addr = 15'h1234;
        post(15'h0300, 8'h77);
        tick();
        cpu_wr_valid = 1'b0;
        checks++;
        if ({sram_oe_n, vid_ack, sram_dout_en, bus_oe1_n} !== 4'b0100) begin
            errors++;
            $display("FAIL read_wins: oe_n,ack,dout_en,oe1_n=%b required 0100",
                     {sram_oe_n, vid_ack, sram_dout_en, bus_oe1_n});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!sram_we_n) we_low++;
        end
        vid_req = 1'b0;
        checks++;
        if (we_low != 0) begin
            errors++;
            $display("FAIL read_wins_no_write: we_n low %0d cycles during reads, required 0", we_low);
        end
        drain("read_wins");
        repeat (2) tick();
        checks++;
        if (mem[15'h0300] !== 8'h77) begin
            errors++;
            $display("FAIL read_wins_write: mem=%h required 77", mem[15'h0300]);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        post(15'h0400, 8'h01); tick();
        post(15'h0401, 8'h02); tick();
        post(15'h0402, 8'h03); tick();
        cpu_wr_valid = 1'b0;
        n = 0;
        while (sram_we_n && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (sram_we_n !== 1'b0 || fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL midop_setup: we_n=%b count=%0d required 0 and 3", sram_we_n, fifo_count);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({sram_cs_n, sram_oe_n, sram_we_n, bus_oe1_n, bus_oe2_n} !== 5'b11111 ||
            sram_dout_en !== 1'b0) begin
            errors++;
            $display("FAIL midop_strobes: cs,oe,we,oe1,oe2=%b dout_en=%b required 11111 and 0",
                     {sram_cs_n, sram_oe_n, sram_we_n, bus_oe1_n, bus_oe2_n}, sram_dout_en);
        end
        checks++;
        if (fifo_count !== 3'd0 || vid_valid !== 1'b0 || vid_ack !== 1'b0 || cpu_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_flush: count=%0d valid=%b ack=%b ready=%b required 0,0,0,1",
                     fifo_count, vid_valid, vid_ack, cpu_wr_ready);
        end
        rst = 1'b0;
        exp_wr.delete();
        repeat (4) tick();
        checks++;
        if (sram_cs_n !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL midop_after: cs_n=%b count=%0d required 1 and 0", sram_cs_n, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_full_starve();
        test_read_wins();
        test_reset_midop();
        checks++;
        if (exp_rd.size() != 0) begin
            errors++;
            $display("FAIL rd_outstanding: %0d reads without vid_valid, required 0", exp_rd.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
